// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//
// Fetch stage that sits directly upstream of the control unit. It holds the PC
// and fetches one 32-bit word at a time from an external instruction memory
// over a req/ack handshake. It then presents the instruction, its opcode and
// its PC to decode/control until downstream retires it. When the instruction
// retires, branch, jump (j/jal) and jump-register (jr) redirects from execute
// select the next PC.
//
// Optional feature macro: PERF_CNT_EN
//   defined   : retired_cnt counts retired instructions and wraps at 2^CNT_W.
//   undefined : no counter logic is built, and retired_cnt is tied to 0.
//   The port list is the same in both builds.
//
// Parameters
//   RESET_PC     PC loaded on reset (word-aligned byte address)
//   CNT_W        width of the retired-instruction counter
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   imem_req     fetch request, held high until imem_ack
//   imem_addr    byte address of the word being fetched (always equals pc)
//   imem_rdata   fetched word, valid in the imem_ack cycle
//   imem_ack     memory response strobe (honoured only while requesting)
//   instr_valid  instruction/opcode/pc hold a valid instruction
//   instr_ready  downstream retires the current instruction this cycle
//   instruction  registered fetched word
//   opcode       instruction[31:26]
//   pc           address of the current instruction
//   pc_plus4     pc + 4 (jal link value)
//   branch_taken resolved beq/bne outcome
//   branch_imm   signed branch offset in words
//   jump         j/jal
//   jump_target  instruction[25:0] of the jump
//   jump_reg     jr
//   rs_data      jr target register value
//   retired_cnt  retired-instruction count
// -----------------------------------------------------------------------------
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    input  logic             imem_ack,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [31:0]      instruction,
    output logic [5:0]       opcode,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    input  logic             branch_taken,
    input  logic [15:0]      branch_imm,
    input  logic             jump,
    input  logic [25:0]      jump_target,
    input  logic             jump_reg,
    input  logic [31:0]      rs_data,
    output logic [CNT_W-1:0] retired_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] next_pc;
    logic [31:0] branch_offset;
    logic        fetch_done;
    logic        retire;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        // NOTE: every clocked register uses <= so that all flops sample the
        // values from before the edge. A blocking = here would let later
        // statements see values that were already updated.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: every signal gets its default first. With the defaults in
        // place, a case branch that does not mention a signal cannot turn
        // that signal into a latch.
        state_next  = state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        fetch_done  = 1'b0;
        retire      = 1'b0;
        unique case (state)
            IDLE: begin
                state_next = REQ;
            end
            REQ: begin
                imem_req = 1'b1;
                // An ack seen in any other state belongs to an abandoned
                // request, so only the REQ state consumes it.
                if (imem_ack) begin
                    fetch_done = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                instr_valid = 1'b1;
                if (instr_ready) begin
                    retire     = 1'b1;
                    state_next = REQ;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------- next PC select
    assign pc_plus4      = pc_q + 32'd4;
    assign branch_offset = {{14{branch_imm[15]}}, branch_imm, 2'b00};

    // Priority: jr over j/jal over a taken branch over sequential flow.
    always_comb begin
        next_pc = pc_plus4;
        if (jump_reg) begin
            next_pc = rs_data & 32'hFFFF_FFFC;
        end else if (jump) begin
            next_pc = {pc_plus4[31:28], jump_target, 2'b00};
        end else if (branch_taken) begin
            next_pc = pc_plus4 + branch_offset;
        end
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            instr_q <= 32'h0000_0000;
        end else begin
            if (fetch_done) begin
                instr_q <= imem_rdata;
            end
            if (retire) begin
                pc_q <= next_pc;
            end
        end
    end

    assign pc          = pc_q;
    assign imem_addr   = pc_q;
    assign instruction = instr_q;
    assign opcode      = instr_q[31:26];

    // ----------------------------------------------------- retired counter
`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (retire) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign retired_cnt = cnt_q;
`else
    assign retired_cnt = '0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
//
// Directed bench for instruction_fetch. A transaction-level model tracks the
// protocol phase, the PC, the held word and the retire count. It computes
// redirect targets from the architectural definitions using plain integer
// arithmetic. A compare process checks every DUT output against the model on
// each falling edge. The directed sequences also pin hand-computed literal
// values such as addresses, opcodes and counts.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_instruction_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          CNT_W    = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             imem_req;
    logic [31:0]      imem_addr;
    logic [31:0]      imem_rdata;
    logic             imem_ack;
    logic             instr_valid;
    logic             instr_ready;
    logic [31:0]      instruction;
    logic [5:0]       opcode;
    logic [31:0]      pc;
    logic [31:0]      pc_plus4;
    logic             branch_taken;
    logic [15:0]      branch_imm;
    logic             jump;
    logic [25:0]      jump_target;
    logic             jump_reg;
    logic [31:0]      rs_data;
    logic [CNT_W-1:0] retired_cnt;

    instruction_fetch #(.RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_ack    (imem_ack),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instruction (instruction),
        .opcode      (opcode),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .branch_taken(branch_taken),
        .branch_imm  (branch_imm),
        .jump        (jump),
        .jump_target (jump_target),
        .jump_reg    (jump_reg),
        .rs_data     (rs_data),
        .retired_cnt (retired_cnt)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int fails   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // --------------------------------------------------------------- model
    typedef enum {M_STARTING, M_FETCHING, M_HOLDING} phase_t;

    phase_t      m_phase = M_STARTING;
    logic [31:0] m_pc    = RESET_PC;
    logic [31:0] m_word  = 32'h0;
    logic [31:0] m_cnt   = 32'h0;
    bit          armed   = 1'b0;

    // Architectural next-PC: jr, then j/jal, then taken branch, else pc+4.
    function automatic logic [31:0] arch_next_pc(
        input logic [31:0] cur, input logic br, input logic [15:0] imm,
        input logic j, input logic [25:0] jt, input logic jr, input logic [31:0] rs);
        logic [31:0] link;
        link = cur + 32'd4;
        if (jr) return rs & ~32'd3;
        if (j)  return (link & 32'hF000_0000) | (32'(jt) * 4);
        if (br) return link + 32'(4 * int'($signed(imm)));
        return link;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_phase = M_STARTING;
            m_pc    = RESET_PC;
            m_word  = 32'h0;
            m_cnt   = 32'h0;
            armed   = 1'b1;
        end else begin
            case (m_phase)
                M_STARTING: m_phase = M_FETCHING;
                M_FETCHING: if (imem_ack) begin
                    m_word  = imem_rdata;
                    m_phase = M_HOLDING;
                end
                M_HOLDING: if (instr_ready) begin
                    m_pc    = arch_next_pc(m_pc, branch_taken, branch_imm,
                                           jump, jump_target, jump_reg, rs_data);
                    m_cnt   = m_cnt + 32'd1;
                    m_phase = M_FETCHING;
                end
                default: m_phase = M_STARTING;
            endcase
        end
    end

    function automatic logic [31:0] exp_cnt(input logic [31:0] n);
`ifdef PERF_CNT_EN
        return n;
`else
        return 32'(n * 0);
`endif
    endfunction

    // ----------------------------------------------------- compare process
    initial begin
        forever begin
            @(negedge clk);
            if (armed) begin
                check("m_imem_req",    32'(imem_req),    32'(m_phase == M_FETCHING));
                check("m_instr_valid", 32'(instr_valid), 32'(m_phase == M_HOLDING));
                check("m_imem_addr",   imem_addr,        m_pc);
                check("m_pc",          pc,               m_pc);
                check("m_pc_plus4",    pc_plus4,         m_pc + 32'd4);
                check("m_instruction", instruction,      m_word);
                check("m_opcode",      32'(opcode),      32'(m_word >> 26));
                check("m_retired_cnt", retired_cnt,      exp_cnt(m_cnt));
            end
        end
    end

    // ---------------------------------------------------------- stimulus
    task automatic clear_redirects();
        instr_ready  = 1'b0;
        branch_taken = 1'b0;
        branch_imm   = 16'h0;
        jump         = 1'b0;
        jump_target  = 26'h0;
        jump_reg     = 1'b0;
        rs_data      = 32'h0;
    endtask

    // Wait, with a bound, for a falling edge at which a request is pending.
    task automatic wait_req();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (imem_req === 1'b1) return;
        end
        check("req_timeout", 32'(imem_req), 32'd1);
    endtask

    // Serve one fetch: acknowledge `lat` cycles after the request is seen.
    task automatic do_fetch(input logic [31:0] word, input int lat);
        wait_req();
        repeat (lat) @(negedge clk);
        check("req_held", 32'(imem_req), 32'd1);
        imem_ack   = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        check("valid_after_ack", 32'(instr_valid), 32'd1);
        check("fetched_word", instruction, word);
    endtask

    task automatic retire(input logic br, input logic [15:0] imm, input logic j,
                          input logic [25:0] jt, input logic jr, input logic [31:0] rs);
        instr_ready  = 1'b1;
        branch_taken = br;
        branch_imm   = imm;
        jump         = j;
        jump_target  = jt;
        jump_reg     = jr;
        rs_data      = rs;
        @(negedge clk);
        clear_redirects();
        check("valid_drops", 32'(instr_valid), 32'd0);
    endtask

    logic [31:0] seq_words [4] = '{32'h8C01_0004, 32'h0022_1820, 32'h1000_0003, 32'h0800_0040};
    logic [5:0]  seq_ops   [4] = '{6'h23, 6'h00, 6'h04, 6'h02};
    logic [31:0] held;

    initial begin
        rst        = 1'b1;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        clear_redirects();

        // T1 reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("t1_pc", pc, 32'h0);
        check("t1_req", 32'(imem_req), 32'd0);
        check("t1_valid", 32'(instr_valid), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("t1_req_after", 32'(imem_req), 32'd1);
        check("t1_addr_after", imem_addr, 32'h0);

        // T2 sequential fetch 0,4,8,C
        for (int i = 0; i < 4; i++) begin
            check("t2_addr", imem_addr, 32'(4 * i));
            do_fetch(seq_words[i], 2);
            check("t2_opcode", 32'(opcode), 32'(seq_ops[i]));
            retire(1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
        end
        check("t2_next_addr", imem_addr, 32'h10);

        // T3 branch back by one word, then forward by three
        do_fetch(32'h1000_FFFF, 1);
        retire(1'b1, 16'hFFFF, 1'b0, 26'h0, 1'b0, 32'h0);
        check("t3_back", imem_addr, 32'h10);
        do_fetch(32'h1000_0003, 1);
        retire(1'b1, 16'h0003, 1'b0, 26'h0, 1'b0, 32'h0);
        check("t3_fwd", imem_addr, 32'h20);

        // T4 jal then jr (jr beats jump and branch)
        do_fetch(32'h0C00_0040, 1);
        check("t4_link", pc_plus4, 32'h24);
        retire(1'b0, 16'h0, 1'b1, 26'h40, 1'b0, 32'h0);
        check("t4_jal", imem_addr, 32'h100);
        do_fetch(32'h03E0_0008, 0);
        retire(1'b1, 16'h0040, 1'b1, 26'h3FF, 1'b1, 32'h27);
        check("t4_jr", imem_addr, 32'h24);

        // T5 stall with toggling redirects, then a stray ack in HOLD
        held = 32'hAC22_0008;
        do_fetch(held, 1);
        for (int i = 0; i < 5; i++) begin
            branch_taken = i[0];
            branch_imm   = 16'h0010;
            jump         = ~i[0];
            @(negedge clk);
            check("t5_stall_instr", instruction, held);
            check("t5_stall_req", 32'(imem_req), 32'd0);
            check("t5_stall_pc", pc, 32'h24);
        end
        clear_redirects();
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        check("t5_stray_ack", instruction, held);
        check("t5_still_valid", 32'(instr_valid), 32'd1);
        retire(1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
        check("t5_next", imem_addr, 32'h28);

        // T6 reset mid-fetch with a simultaneous and a late ack
        wait_req();
        rst        = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hFC00_0000;
        @(negedge clk);
        rst = 1'b0;
        check("t6_valid", 32'(instr_valid), 32'd0);
        check("t6_req", 32'(imem_req), 32'd0);
        check("t6_pc", pc, RESET_PC);
        check("t6_cnt_clr", retired_cnt, 32'h0);
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        check("t6_restart_req", 32'(imem_req), 32'd1);
        check("t6_restart_addr", imem_addr, RESET_PC);
        check("t6_no_word", instruction, 32'h0);
        for (int i = 0; i < 3; i++) begin
            do_fetch(32'h2000_0000 + 32'(i), 1);
            retire(1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
        end
`ifdef PERF_CNT_EN
        check("t6_cnt3", retired_cnt, 32'd3);
`else
        check("t6_cnt3", retired_cnt, 32'd0);
`endif
        check("t6_addr3", imem_addr, 32'hC);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_cnt_rst", retired_cnt, 32'd0);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
